// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO slice.
// Read-mode selector values and a width helper for pointer/level vectors.
// Combinational helpers only; no state, no ports.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bits needed to hold 0..depth inclusive for a power-of-two depth:
  // clog2(depth) address bits plus one wrap bit.
  function automatic int fifo_level_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// DEPTH x DATA_WIDTH storage array with one write port and one combinational read port.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates wr_en. Ports: w_clk, w_rst (async active-low),
//   wr_en/wr_addr/wr_data write port, rd_addr -> rd_data read port.
module fifo_sync_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Reset clears every word so FWFT mode presents zero out of reset.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_buf.sv
// Single-clock FIFO: pointer control, full/empty/threshold flags, level, sticky errors.
// Latency: FWFT=0 rd_data one cycle after accepted rd_en; FWFT=1 head word shown combinationally.
// Backpressure: writes refused while full (overflow set), reads refused while empty (underflow set).
// Ports: w_clk, w_rst (async active-low), clr (sync flush), wr_en/wr_data, rd_en,
//   rd_data/rd_valid, full/empty, almost_full/almost_empty, level, overflow/underflow.
module fifo_sync_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = FIFO_MODE_REG
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = fifo_level_width(DEPTH);

  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  full_w, empty_w;
  logic                  wr_acc, rd_acc;
  logic [PTR_W-1:0]      level_w;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Same address with differing wrap bits means the writer is a full lap ahead.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]) &&
                   (wr_ptr_q[PTR_W-1]   != rd_ptr_q[PTR_W-1]);
  assign level_w = wr_ptr_q - rd_ptr_q;

  // Acceptance uses start-of-cycle flags, so a full FIFO refuses a write even
  // when a read frees a slot in the same cycle (and symmetrically for empty).
  assign wr_acc = wr_en && !full_w  && !clr;
  assign rd_acc = rd_en && !empty_w && !clr;

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[PTR_W-2:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[PTR_W-2:0]),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      // Flush: requests this cycle are dropped silently; memory is left alone.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_data_d  = mem_rd_data;
        rd_valid_d = 1'b1;
      end
      if (wr_en && full_w)  ovf_d = 1'b1;
      if (rd_en && empty_w) udf_d = 1'b1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign level        = level_w;
  assign almost_full  = (level_w >= AF_LVL);
  assign almost_empty = (level_w <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // FWFT shows the head word directly; registered mode shows the last popped word.
  assign rd_data  = (FWFT == FIFO_MODE_FWFT) ? mem_rd_data : rd_data_q;
  assign rd_valid = (FWFT == FIFO_MODE_FWFT) ? !empty_w    : rd_valid_q;

endmodule

// File: tb/tb_fifo_sync_buf.sv
// Bench for fifo_sync_buf: one registered-read and one FWFT instance share stimulus.
// A queue-based reference model predicts every output; directed literal checks pin it.
// Inputs change 1ns after the rising edge; outputs compared on the falling edge.
module tb_fifo_sync_buf;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b0;
  logic          clr   = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] r_rd_data, f_rd_data;
  logic          r_rd_valid, f_rd_valid;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [AW:0]   r_level, f_level;

  always #5 w_clk = ~w_clk;

  fifo_sync_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_r (
    .w_clk(w_clk), .w_rst(w_rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .level(r_level), .overflow(r_ovf), .underflow(r_udf));

  fifo_sync_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_f (
    .w_clk(w_clk), .w_rst(w_rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf), .underflow(f_udf));

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_rd;
  bit            chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  // One clock edge of behaviour from the current inputs.
  task automatic model_step();
    int sz;
    bit fl, em;
    sz = q.size();
    fl = (sz == DEPTH);
    em = (sz == 0);
    m_rv = 1'b0;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr_en && fl) m_ovf = 1'b1;
      if (rd_en && em) m_udf = 1'b1;
      if (rd_en && !em) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (wr_en && !fl) q.push_back(wr_data);
    end
  endtask

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge w_clk);
    #1;
    model_step();
  endtask

  // Compare process: every falling edge while out of reset.
  always @(negedge w_clk) begin
    if (chk_en && w_rst) begin
      chk("r_level", int'(r_level), q.size());
      chk("f_level", int'(f_level), q.size());
      chk("r_full",  int'(r_full),  int'(q.size() == DEPTH));
      chk("f_full",  int'(f_full),  int'(q.size() == DEPTH));
      chk("r_empty", int'(r_empty), int'(q.size() == 0));
      chk("f_empty", int'(f_empty), int'(q.size() == 0));
      chk("r_af",    int'(r_af),    int'(q.size() >= AF));
      chk("f_af",    int'(f_af),    int'(q.size() >= AF));
      chk("r_ae",    int'(r_ae),    int'(q.size() <= AE));
      chk("f_ae",    int'(f_ae),    int'(q.size() <= AE));
      chk("r_ovf",   int'(r_ovf),   int'(m_ovf));
      chk("f_ovf",   int'(f_ovf),   int'(m_ovf));
      chk("r_udf",   int'(r_udf),   int'(m_udf));
      chk("f_udf",   int'(f_udf),   int'(m_udf));
      chk("r_rd_valid", int'(r_rd_valid), int'(m_rv));
      chk("r_rd_data",  int'(r_rd_data),  int'(m_rd));
      chk("f_rd_valid", int'(f_rd_valid), int'(q.size() != 0));
      if (q.size() != 0) chk("f_rd_data", int'(f_rd_data), int'(q[0]));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r_empty"}, int'(r_empty), 1);
    chk({tag, "_r_ae"},    int'(r_ae),    1);
    chk({tag, "_r_full"},  int'(r_full),  0);
    chk({tag, "_r_af"},    int'(r_af),    0);
    chk({tag, "_r_level"}, int'(r_level), 0);
    chk({tag, "_r_ovf"},   int'(r_ovf),   0);
    chk({tag, "_r_udf"},   int'(r_udf),   0);
    chk({tag, "_r_rv"},    int'(r_rd_valid), 0);
    chk({tag, "_r_rd"},    int'(r_rd_data),  0);
    chk({tag, "_f_empty"}, int'(f_empty), 1);
    chk({tag, "_f_level"}, int'(f_level), 0);
    chk({tag, "_f_rv"},    int'(f_rd_valid), 0);
    chk({tag, "_f_rd"},    int'(f_rd_data),  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int pw, pr;

    // Reset state
    #12;
    chk_reset_outputs("rst");
    @(negedge w_clk);
    w_rst = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Fill with 0x11..0x18, watching almost_full threshold
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      if (i == 4) chk("af_at5", int'(r_almost_full_dummy(r_af)), 0);
      if (i == 5) chk("af_at6", int'(r_af), 1);
    end
    chk("fill_level", int'(r_level), 8);
    chk("fill_full",  int'(r_full),  1);

    // Drain, each word one cycle after rd_en
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pop_data",  int'(r_rd_data),  int'(8'h11 + 8'(i)));
      chk("pop_valid", int'(r_rd_valid), 1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_empty", int'(r_empty), 1);
    chk("drain_rv",    int'(r_rd_valid), 0);

    // Overflow on full, 0xAA never stored
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set",   int'(r_ovf),   1);
    chk("ovf_level", int'(r_level), 8);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_last", int'(r_rd_data), 8'h27);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_level", int'(r_level), 0);
    chk("clr_ovf",   int'(r_ovf),   0);
    chk("clr_empty", int'(r_empty), 1);

    // Underflow on empty; rd_data holds last word
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set",  int'(r_udf),      1);
    chk("udf_rv",   int'(r_rd_valid), 0);
    chk("udf_hold", int'(r_rd_data),  8'h27);

    // Full with simultaneous write+read
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("fb_level", int'(r_level),   7);
    chk("fb_ovf",   int'(r_ovf),     1);
    chk("fb_data",  int'(r_rd_data), 8'h30);

    // Empty with simultaneous write+read
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h42, 1'b1, 1'b0);
    chk("eb_level", int'(r_level),    1);
    chk("eb_udf",   int'(r_udf),      1);
    chk("eb_rv",    int'(r_rd_valid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around at constant level 3
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h53 + 8'(i), 1'b1, 1'b0);
      chk("wrap_level", int'(r_level), 3);
      chk("wrap_data",  int'(r_rd_data), int'(8'h50 + 8'(i)));
    end
    chk("wrap_ovf", int'(r_ovf), 0);
    chk("wrap_udf", int'(r_udf), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT presentation
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
    chk("fwft_rv",   int'(f_rd_valid), 1);
    chk("fwft_data", int'(f_rd_data),  8'h5C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_rv",    int'(f_rd_valid), 0);
    chk("fwft_pop_empty", int'(f_empty),    1);

    // Randomised traffic with alternating fill/drain bias
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 60) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      d  = 8'($urandom);
      cyc($urandom_range(0, 99) < pw, d, $urandom_range(0, 99) < pr, $urandom_range(0, 59) == 0);
    end

    // Asynchronous reset in the middle of a burst
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h64, 1'b1, 1'b0);
    #1;
    w_rst = 1'b0;
    #1;
    chk_reset_outputs("mid");
    model_reset();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_level", int'(f_level),   1);
    chk("post_rst_fwft",  int'(f_rd_data), 8'h77);
    for (int i = 0; i < 60; i++) begin
      d = 8'($urandom);
      cyc($urandom_range(0, 1) == 1, d, $urandom_range(0, 1) == 1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge w_clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic r_almost_full_dummy(input logic v);
    return v;
  endfunction

endmodule
